// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared types and default sizing for adder_share_arbiter.
package adder_share_pkg;
   localparam int N_DEF = 21;
   localparam int NREQ_DEF = 4;
   localparam int MAX_LEN_DEF = 20;
   localparam int ID_W = $clog2(NREQ_DEF);
   localparam int CNT_W = $clog2(MAX_LEN_DEF + 1);
   typedef enum logic {IDLE, LOCKED} state_t;
endpackage

// File: rtl/adder.sv
// adder: combinational N-bit adder, carry dropped.
module adder #(
   parameter int N = 21
) (
   input  logic [N-1:0] input1,
   input  logic [N-1:0] input2,
   output logic [N-1:0] sum
);
   assign sum = input1 + input2;
endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   id,
   output logic            any
);
   // Scan from the farthest position back to ptr so the closest requester wins.
   always_comb begin
      gnt = '0;
      id = '0;
      any = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[(int'(ptr) + i) % NREQ]) begin
            gnt = '0;
            gnt[(int'(ptr) + i) % NREQ] = 1'b1;
            id = IW'((int'(ptr) + i) % NREQ);
            any = 1'b1;
         end
      end
   end
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: packet-locked round-robin sharing of one adder among NREQ sources.
// Define OPERAND_ISOLATION_EN to load operand registers only on accepted flits.
module adder_share_arbiter
   import adder_share_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int NREQ = NREQ_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF,
   parameter int IW = $clog2(NREQ),
   parameter int CW = $clog2(MAX_LEN + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   input  logic [NREQ-1:0] req_last,
   input  logic [NREQ*N-1:0] req_op1,
   input  logic [NREQ*N-1:0] req_op2,
   output logic [NREQ-1:0] req_ready,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [N-1:0]    res_sum,
   output logic [IW-1:0]   res_id,
   output logic            res_last,
   output logic            err_len
);
   state_t state, state_nx;
   logic [IW-1:0] lock_id, lock_id_nx, rr_ptr, rr_ptr_nx, arb_id, g, g_next;
   logic [CW-1:0] flit_cnt, flit_cnt_nx, cnt_inc;
   logic [NREQ-1:0] arb_gnt;
   logic arb_any, adv, accept, last_in, fin;
   logic [N-1:0] op1_q, op2_q;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req(req_valid),
      .ptr(rr_ptr),
      .gnt(arb_gnt),
      .id(arb_id),
      .any(arb_any)
   );

   adder #(.N(N)) u_adder (
      .input1(op1_q),
      .input2(op2_q),
      .sum(res_sum)
   );

   assign adv = !res_valid || res_ready;
   assign g = (state == LOCKED) ? lock_id : (arb_any ? arb_id : rr_ptr);
   assign g_next = (g == IW'(NREQ - 1)) ? '0 : g + IW'(1);
   assign req_ready = !adv ? '0 : (state == LOCKED) ? (NREQ'(1) << lock_id) : arb_gnt;
   assign accept = |(req_valid & req_ready);
   assign last_in = req_last[g];
   assign cnt_inc = flit_cnt + CW'(1);
   assign fin = last_in || (cnt_inc == CW'(MAX_LEN));

   always_comb begin
      state_nx = state;
      lock_id_nx = lock_id;
      flit_cnt_nx = flit_cnt;
      rr_ptr_nx = rr_ptr;
      if (accept) begin
         state_nx = fin ? IDLE : LOCKED;
         lock_id_nx = g;
         flit_cnt_nx = fin ? '0 : cnt_inc;
         rr_ptr_nx = fin ? g_next : rr_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         lock_id <= '0;
         flit_cnt <= '0;
         rr_ptr <= '0;
      end else begin
         state <= state_nx;
         lock_id <= lock_id_nx;
         flit_cnt <= flit_cnt_nx;
         rr_ptr <= rr_ptr_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_id <= '0;
         res_last <= 1'b0;
         err_len <= 1'b0;
         op1_q <= '0;
         op2_q <= '0;
      end else begin
         err_len <= err_len | (accept && fin && !last_in);
         if (adv) begin
            res_valid <= accept;
            if (accept) begin
               res_id <= g;
               res_last <= fin;
            end
         end
`ifdef OPERAND_ISOLATION_EN
         if (accept) begin
`else
         if (adv) begin
`endif
            op1_q <= req_op1[g*N +: N];
            op2_q <= req_op2[g*N +: N];
         end
      end
   end
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: vector table, directed corner cases and random traffic against a spec-level model.
module tb_adder_share_arbiter;
   localparam int N = 21;
   localparam int NREQ = 4;
   localparam int MAX_LEN = 20;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
   logic [NREQ*N-1:0] req_op1 = '0, req_op2 = '0;
   logic res_valid, res_last, err_len;
   logic res_ready = 1'b1;
   logic [N-1:0] res_sum;
   logic [IW-1:0] res_id;

   always #5 clk = ~clk;

   adder_share_arbiter dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_last(req_last),
      .req_op1(req_op1), .req_op2(req_op2),
      .req_ready(req_ready),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_id(res_id), .res_last(res_last),
      .err_len(err_len)
   );

   typedef struct {
      int r;
      logic [N-1:0] a, b;
      bit l;
      logic [N-1:0] s;
      bit el;
   } vec_t;

   int n_cmp = 0, n_err = 0;
   int m_owner, m_ptr, m_cnt, m_id, m_gid;
   bit m_valid, m_last, m_err, m_acc;
   logic [N-1:0] m_sum;
   int rem[NREQ];

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic set_req(int r, bit v, bit l, logic [N-1:0] a, logic [N-1:0] b);
      req_valid[r] = v;
      req_last[r] = l;
      req_op1[r*N +: N] = a;
      req_op2[r*N +: N] = b;
   endtask

   task automatic clr();
      req_valid = '0;
      req_last = '0;
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_cnt = 0;
      m_valid = 0; m_last = 0; m_err = 0; m_sum = '0; m_id = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One clock: predict grant from the arbitration rules, apply the edge, compare outputs.
   task automatic step();
      bit adv;
      int g, c;
      logic [NREQ-1:0] er;
      #1;
      adv = !m_valid || res_ready;
      g = m_owner;
      if (g < 0)
         for (int i = 0; i < NREQ; i++)
            if (g < 0 && req_valid[(m_ptr + i) % NREQ]) g = (m_ptr + i) % NREQ;
      er = (adv && g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      m_acc = 0;
      if (g >= 0) m_acc = adv && req_valid[g];
      m_gid = g;
      if (adv) begin
         m_valid = m_acc;
         if (m_acc) begin
            m_sum = req_op1[g*N +: N] + req_op2[g*N +: N];
            m_id = g;
            c = (m_owner < 0 ? 0 : m_cnt) + 1;
            m_last = req_last[g] || c == MAX_LEN;
            if (m_last) begin
               if (!req_last[g]) m_err = 1;
               m_owner = -1; m_cnt = 0; m_ptr = (g + 1) % NREQ;
            end else begin
               m_owner = g; m_cnt = c;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("err_len", 32'(err_len), 32'(m_err));
      if (m_valid) begin
         chk("res_sum", 32'(res_sum), 32'(m_sum));
         chk("res_id", 32'(res_id), 32'(m_id));
         chk("res_last", 32'(res_last), 32'(m_last));
      end
   endtask

   task automatic src_cycle(bit rnd);
      for (int r = 0; r < NREQ; r++)
         if (rem[r] > 0 && (!rnd || $urandom_range(3) != 0))
            set_req(r, 1, rem[r] == 1, N'($urandom), N'($urandom));
         else
            set_req(r, 0, 0, N'($urandom), N'($urandom));
      res_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      step();
      if (m_acc) rem[m_gid]--;
      if (rnd)
         for (int r = 0; r < NREQ; r++)
            if (rem[r] == 0 && $urandom_range(2) == 0) rem[r] = $urandom_range(1, 24);
   endtask

   initial begin
      vec_t tbl[6];
      int ids[$];
      tbl[0] = '{0, 21'h1, 21'h10, 0, 21'h11, 0};
      tbl[1] = '{0, 21'h2, 21'h10, 0, 21'h12, 0};
      tbl[2] = '{0, 21'h3, 21'h10, 1, 21'h13, 1};
      tbl[3] = '{1, 21'h1FFFFF, 21'h000001, 1, 21'h0, 1};
      tbl[4] = '{2, 21'h5, 21'h6, 0, 21'hB, 0};
      tbl[5] = '{2, 21'h7, 21'h8, 1, 21'hF, 1};
      for (int r = 0; r < NREQ; r++) rem[r] = 0;
      @(negedge clk);
      do_reset();
      chk("rst_valid", 32'(res_valid), 0);
      chk("rst_sum", 32'(res_sum), 0);
      chk("rst_id", 32'(res_id), 0);
      chk("rst_last", 32'(res_last), 0);
      chk("rst_err", 32'(err_len), 0);
      chk("rst_ready", 32'(req_ready), 0);
      for (int i = 0; i < 6; i++) begin
         clr();
         set_req(tbl[i].r, 1, tbl[i].l, tbl[i].a, tbl[i].b);
         step();
         chk("tbl_valid", 32'(res_valid), 1);
         chk("tbl_sum", 32'(res_sum), 32'(tbl[i].s));
         chk("tbl_id", 32'(res_id), 32'(tbl[i].r));
         chk("tbl_last", 32'(res_last), 32'(tbl[i].el));
      end
      clr();
      step();
      chk("idle_valid", 32'(res_valid), 0);

      // two competing 2-flit packets from a fresh pointer
      do_reset();
      rem[0] = 2;
      rem[2] = 2;
      for (int k = 0; k < 8; k++) begin
         src_cycle(0);
         if (res_valid) ids.push_back(int'(res_id));
      end
      chk("rr_count", 32'(ids.size()), 4);
      if (ids.size() == 4) begin
         chk("rr_id0", 32'(ids[0]), 0);
         chk("rr_id1", 32'(ids[1]), 0);
         chk("rr_id2", 32'(ids[2]), 2);
         chk("rr_id3", 32'(ids[3]), 2);
      end
      clr();
      set_req(1, 1, 1, 21'h1, 21'h1);
      set_req(3, 1, 1, 21'h3, 21'h3);
      step();
      chk("rr_ptr3", 32'(res_id), 3);

      // output stall mid-packet
      clr();
      set_req(0, 1, 0, 21'h1, 21'h1);
      step();
      set_req(0, 1, 0, 21'h2, 21'h2);
      step();
      res_ready = 1'b0;
      set_req(0, 1, 1, 21'h3, 21'h3);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_sum", 32'(res_sum), 4);
         chk("stall_valid", 32'(res_valid), 1);
         chk("stall_ready", 32'(req_ready), 0);
      end
      res_ready = 1'b1;
      step();
      chk("stall_resume", 32'(res_sum), 6);
      chk("stall_last", 32'(res_last), 1);

      // overlong packet is cut at MAX_LEN
      clr();
      for (int k = 1; k <= 20; k++) begin
         set_req(0, 1, 0, N'(k), 21'h0);
         if (k >= 2) set_req(1, 1, 1, 21'h7, 21'h7);
         step();
      end
      chk("f20_last", 32'(res_last), 1);
      chk("f20_err", 32'(err_len), 1);
      chk("f20_sum", 32'(res_sum), 20);
      set_req(0, 1, 0, 21'd21, 21'h0);
      step();
      chk("after_cut_id", 32'(res_id), 1);
      chk("after_cut_sum", 32'(res_sum), 14);
      set_req(1, 0, 0, 21'h0, 21'h0);
      for (int k = 21; k <= 25; k++) begin
         set_req(0, 1, k == 25, N'(k), 21'h0);
         step();
      end
      chk("f25_last", 32'(res_last), 1);
      chk("f25_sum", 32'(res_sum), 25);

      // reset in the middle of a packet
      clr();
      set_req(1, 1, 0, 21'h4, 21'h4);
      step();
      step();
      set_req(0, 1, 1, 21'h9, 21'h1);
      step();
      do_reset();
      chk("mid_rst_valid", 32'(res_valid), 0);
      chk("mid_rst_err", 32'(err_len), 0);
      chk("mid_rst_ready", 32'(req_ready), 1);
      step();
      chk("mid_rst_id", 32'(res_id), 0);
      chk("mid_rst_sum", 32'(res_sum), 10);

      clr();
      for (int k = 0; k < 600; k++) src_cycle(1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
